// File: rtl/vec_pkg.sv
// vec_pkg: opcodes, default widths, the queued instruction type and the head hazard check
package vec_pkg;
   function automatic int bitwidth(int x);
      return x < 2 ? 1 : $clog2(x);
   endfunction
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_LOAD = 2'b10, OP_STORE = 2'b11;
   localparam int P_NUM_REGS = 4, P_MVL = 16, P_ADDRESS_WIDTH = 10, P_DEPTH = 4, P_STALL_CNT_W = 16;
   localparam int P_RW = bitwidth(P_NUM_REGS), P_LW = bitwidth(P_MVL);
   typedef enum logic [1:0] {EMPTY, READY, BLOCKED} state_t;
   typedef struct packed {
      logic [1:0] op;
      logic [P_RW-1:0] src1;
      logic [P_RW-1:0] src2;
      logic [P_RW-1:0] dst;
      logic [P_ADDRESS_WIDTH-1:0] addr;
      logic [P_LW-1:0] vlr;
   } instr_t;
   // store reads src1 only, load writes dst only, add/sub touch all three
   function automatic logic hazard(instr_t i, logic [P_NUM_REGS-1:0] p);
      return i.op == OP_STORE ? p[i.src1] : i.op == OP_LOAD ? p[i.dst] : p[i.src1] | p[i.src2] | p[i.dst];
   endfunction
endpackage

// File: rtl/vec_issue_queue_if.sv
// vec_issue_queue_if: decode-side request bus plus control-unit issue bus of the issue queue
interface vec_issue_queue_if import vec_pkg::*; #(
   parameter int NUM_REGS = P_NUM_REGS,
   parameter int MVL = P_MVL,
   parameter int ADDRESS_WIDTH = P_ADDRESS_WIDTH,
   parameter int DEPTH = P_DEPTH,
   parameter int STALL_CNT_W = P_STALL_CNT_W
);
   localparam int RW = bitwidth(NUM_REGS), LW = bitwidth(MVL), CW = bitwidth(DEPTH + 1);
   logic req_valid_i, req_ready_o;
   logic [1:0] req_op_i;
   logic [RW-1:0] req_src1_i, req_src2_i, req_dst_i;
   logic [ADDRESS_WIDTH-1:0] req_addr_i;
   logic [LW-1:0] req_vlr_i;
   logic flush_i, cu_stall_i;
   logic [NUM_REGS-1:0] reg_done_i;
   logic add_o, sub_o, load_o, store_o;
   logic [RW-1:0] src1_o, src2_o, dst_o;
   logic [ADDRESS_WIDTH-1:0] addr_o;
   logic [LW-1:0] vlr_o;
   logic [CW-1:0] count_o;
   logic [NUM_REGS-1:0] pending_o;
   logic [STALL_CNT_W-1:0] hazard_stall_cnt_o;
   modport slave(
      input req_valid_i, req_op_i, req_src1_i, req_src2_i, req_dst_i, req_addr_i, req_vlr_i,
      input flush_i, cu_stall_i, reg_done_i,
      output req_ready_o, add_o, sub_o, load_o, store_o, src1_o, src2_o, dst_o, addr_o, vlr_o,
      output count_o, pending_o, hazard_stall_cnt_o
   );
   modport master(
      output req_valid_i, req_op_i, req_src1_i, req_src2_i, req_dst_i, req_addr_i, req_vlr_i,
      output flush_i, cu_stall_i, reg_done_i,
      input req_ready_o, add_o, sub_o, load_o, store_o, src1_o, src2_o, dst_o, addr_o, vlr_o,
      input count_o, pending_o, hazard_stall_cnt_o
   );
endinterface

// File: rtl/vec_sync_fifo.sv
// vec_sync_fifo: power-of-two circular buffer with push/pop/flush and occupancy count
module vec_sync_fifo import vec_pkg::*; #(
   parameter int W = 8,
   parameter int DEPTH = 4
) (
   input logic clk_i,
   input logic rst_i,
   input logic push_i,
   input logic pop_i,
   input logic flush_i,
   input logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic [bitwidth(DEPTH + 1)-1:0] count_o
);
   localparam int PW = bitwidth(DEPTH), CW = bitwidth(DEPTH + 1);
   logic [W-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i || flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   always_ff @(posedge clk_i)
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
   assign data_o = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/vec_issue_queue.sv
// vec_issue_queue: in-order queue of vector instructions, issued one per cycle to the
// control unit once the head is clear of RAW/WAW hazards in the pending-write scoreboard.
module vec_issue_queue import vec_pkg::*; #(
   parameter int NUM_REGS = P_NUM_REGS,
   parameter int MVL = P_MVL,
   parameter int ADDRESS_WIDTH = P_ADDRESS_WIDTH,
   parameter int DEPTH = P_DEPTH,
   parameter int STALL_CNT_W = P_STALL_CNT_W
) (
   input logic clk_i,
   input logic rst_i,
   vec_issue_queue_if.slave io
);
   localparam int CW = bitwidth(DEPTH + 1);
   localparam int W = 2 + 3 * bitwidth(NUM_REGS) + ADDRESS_WIDTH + bitwidth(MVL);
   state_t state_q, state_d;
   instr_t req, head, out_q;
   logic [CW-1:0] count;
   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic [3:0] ops_q, ops_d;
   logic push, issue, hz, hz_m;
   assign req = '{op: io.req_op_i, src1: io.req_src1_i, src2: io.req_src2_i, dst: io.req_dst_i,
                  addr: io.req_addr_i, vlr: io.req_vlr_i};
   vec_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(push), .pop_i(issue), .flush_i(io.flush_i),
      .data_i(req), .data_o(head), .count_o(count)
   );
   assign io.req_ready_o = count < CW'(DEPTH);
   assign push = io.req_valid_i && io.req_ready_o && !io.flush_i;
   assign hz = hazard(head, pending_q);
   // a register whose write completes this cycle already counts as free for the next state
   assign hz_m = hazard(head, pending_q & ~io.reg_done_i);
   assign issue = state_q == READY && !io.cu_stall_i && !hz && !io.flush_i;
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: state_d = push ? READY : EMPTY;
         READY: state_d = issue ? (count == CW'(1) && !push ? EMPTY : READY) : (hz_m ? BLOCKED : READY);
         default: state_d = hz_m ? BLOCKED : READY;
      endcase
      if (io.flush_i) state_d = EMPTY;
      pending_d = (pending_q & ~io.reg_done_i) | (issue && head.op != OP_STORE ? NUM_REGS'(1) << head.dst : '0);
      stall_d = state_q == BLOCKED && !(&stall_q) ? stall_q + 1'b1 : stall_q;
      ops_d = {4{issue}} & {head.op == OP_STORE, head.op == OP_LOAD, head.op == OP_SUB, head.op == OP_ADD};
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= EMPTY;
         pending_q <= '0;
         stall_q <= '0;
         ops_q <= '0;
         out_q <= '0;
      end else begin
         state_q <= state_d;
         pending_q <= pending_d;
         stall_q <= stall_d;
         ops_q <= ops_d;
         if (issue) out_q <= head;
      end
   assign {io.store_o, io.load_o, io.sub_o, io.add_o} = ops_q;
   assign io.src1_o = out_q.src1;
   assign io.src2_o = out_q.src2;
   assign io.dst_o = out_q.dst;
   assign io.addr_o = out_q.addr;
   assign io.vlr_o = out_q.vlr;
   assign io.count_o = count;
   assign io.pending_o = pending_q;
   assign io.hazard_stall_cnt_o = stall_q;
endmodule
